// File: rtl/sampler_ctrl_pkg.sv
// Shared types and constants for the sampler sweep controller.
package sampler_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned IDX_WIDTH_DEF  = 4;
  localparam int unsigned SEED_CYCLES    = 2;

  localparam logic [1:0] SEG_INVALID = 2'd0;
  localparam logic [1:0] SEG_TYPE1   = 2'd1;
  localparam logic [1:0] SEG_TYPE2   = 2'd2;
  localparam logic [1:0] SEG_TYPE3   = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StSeed,
    StFetch,
    StLoad,
    StPropose,
    StWait,
    StCommit,
    StNext,
    StDone
  } state_t;

  // Saturating increment for the 8-bit error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sampler_range_check.sv
// Signed range check of a value against [lo, hi] with clamped result.
module sampler_range_check #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] in_value,
  input  logic signed [DATA_WIDTH-1:0] in_lo,
  input  logic signed [DATA_WIDTH-1:0] in_hi,
  output logic                         out_in_range,
  output logic                         out_below,
  output logic                         out_above,
  output logic signed [DATA_WIDTH-1:0] out_clamped
);

  // Flags are mutually exclusive only when lo <= hi.
  always_comb begin
    out_below    = (in_value < in_lo);
    out_above    = (in_value > in_hi);
    out_in_range = !out_below && !out_above;
    if (out_below)      out_clamped = in_lo;
    else if (out_above) out_clamped = in_hi;
    else                out_clamped = in_value;
  end

endmodule

// File: rtl/sampler_sweep_controller.sv
// Sequences the Sampler through MCMC sweeps over a segment table.
// Optional build macro RANGE_CLAMP_EN: out-of-range proposals are clamped
// and written instead of dropped (error count still increments).
module sampler_sweep_controller
  import sampler_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned IDX_WIDTH       = IDX_WIDTH_DEF,
  parameter int unsigned SWEEP_WIDTH     = 8,
  parameter int unsigned SAMPLER_LATENCY = 1
) (
  input  logic                         in_clock,
  input  logic                         in_reset,
  input  logic                         in_start,
  input  logic [7:0]                   in_seed,
  input  logic [IDX_WIDTH:0]           in_num_vars,
  input  logic [SWEEP_WIDTH-1:0]       in_num_sweeps,
  output logic [IDX_WIDTH-1:0]         out_seg_addr,
  input  logic signed [DATA_WIDTH-1:0] in_seg_from,
  input  logic signed [DATA_WIDTH-1:0] in_seg_to,
  input  logic [1:0]                   in_seg_type,
  input  logic signed [DATA_WIDTH-1:0] in_seg_weight,
  output logic                         out_sampler_reset,
  output logic                         out_sampler_enable,
  output logic [7:0]                   out_sampler_seed,
  output logic signed [DATA_WIDTH-1:0] out_from,
  output logic signed [DATA_WIDTH-1:0] out_to,
  output logic [1:0]                   out_segment_type,
  output logic signed [DATA_WIDTH-1:0] out_segment_weight,
  input  logic signed [DATA_WIDTH-1:0] in_proposed_value,
  output logic                         out_var_write,
  output logic [IDX_WIDTH-1:0]         out_var_index,
  output logic signed [DATA_WIDTH-1:0] out_var_value,
  output logic                         out_busy,
  output logic                         out_done,
  output logic [7:0]                   out_error_count
);

  localparam logic [7:0] SeedLast = 8'(SEED_CYCLES - 1);
  localparam logic [7:0] WaitLast = 8'(SAMPLER_LATENCY - 1);
  localparam logic signed [DATA_WIDTH-1:0] DataMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t                         r_state;
  logic [7:0]                     r_cnt;
  logic [IDX_WIDTH:0]             r_idx;       // one extra bit so num_vars=2^IDX_WIDTH works
  logic [IDX_WIDTH:0]             r_num_vars;
  logic [SWEEP_WIDTH-1:0]         r_sweep;
  logic [SWEEP_WIDTH-1:0]         r_num_sweeps;
  logic [7:0]                     r_seed;
  logic                           r_sampler_reset;
  logic                           r_sampler_enable;
  logic signed [DATA_WIDTH-1:0]   r_from;
  logic signed [DATA_WIDTH-1:0]   r_to;
  logic [1:0]                     r_type;
  logic signed [DATA_WIDTH-1:0]   r_weight;
  logic                           r_var_write;
  logic [IDX_WIDTH-1:0]           r_var_index;
  logic signed [DATA_WIDTH-1:0]   r_var_value;
  logic                           r_busy;
  logic                           r_done;
  logic [7:0]                     r_err;

  logic signed [DATA_WIDTH-1:0]   w_chk_val;
  logic signed [DATA_WIDTH-1:0]   w_chk_lo;
  logic signed [DATA_WIDTH-1:0]   w_chk_hi;
  logic                           w_in_range;
  logic                           w_below;
  logic                           w_above;
  logic signed [DATA_WIDTH-1:0]   w_clamped;
  logic                           w_last_var;
  logic                           w_last_sweep;

  // One checker serves both states: in LOAD it tests to >= from (below => from > to),
  // elsewhere it tests the proposal against the held segment bounds.
  always_comb begin
    if (r_state == StLoad) begin
      w_chk_val = in_seg_to;
      w_chk_lo  = in_seg_from;
      w_chk_hi  = DataMax;
    end else begin
      w_chk_val = in_proposed_value;
      w_chk_lo  = r_from;
      w_chk_hi  = r_to;
    end
  end

  sampler_range_check #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_range_check (
    .in_value    (w_chk_val),
    .in_lo       (w_chk_lo),
    .in_hi       (w_chk_hi),
    .out_in_range(w_in_range),
    .out_below   (w_below),
    .out_above   (w_above),
    .out_clamped (w_clamped)
  );

  assign w_last_var   = (r_idx == r_num_vars - (IDX_WIDTH + 1)'(1));
  assign w_last_sweep = (r_sweep == r_num_sweeps - SWEEP_WIDTH'(1));

  // Main sequencer: all outputs are registered here.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state          <= StIdle;
      r_cnt            <= '0;
      r_idx            <= '0;
      r_num_vars       <= '0;
      r_sweep          <= '0;
      r_num_sweeps     <= '0;
      r_seed           <= '0;
      r_sampler_reset  <= 1'b0;
      r_sampler_enable <= 1'b0;
      r_from           <= '0;
      r_to             <= '0;
      r_type           <= '0;
      r_weight         <= '0;
      r_var_write      <= 1'b0;
      r_var_index      <= '0;
      r_var_value      <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= '0;
    end else begin
      r_var_write <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (in_start) begin
            r_seed       <= (in_seed == 8'd0) ? 8'd1 : in_seed;
            r_num_vars   <= in_num_vars;
            r_num_sweeps <= in_num_sweeps;
            r_err        <= '0;
            r_busy       <= 1'b1;
            r_idx        <= '0;
            r_sweep      <= '0;
            r_cnt        <= '0;
            if (in_num_vars == '0 || in_num_sweeps == '0) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_sampler_reset  <= 1'b1;
              r_sampler_enable <= 1'b1;
              r_state          <= StSeed;
            end
          end
        end
        StSeed: begin
          if (r_cnt == SeedLast) begin
            r_sampler_reset  <= 1'b0;
            r_sampler_enable <= 1'b0;
            r_state          <= StFetch;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StFetch: r_state <= StLoad;
        StLoad: begin
          r_from   <= in_seg_from;
          r_to     <= in_seg_to;
          r_type   <= in_seg_type;
          r_weight <= in_seg_weight;
          if (in_seg_type == SEG_INVALID || w_below) begin
            r_err   <= sat_inc8(r_err);
            r_state <= StNext;
          end else begin
            r_sampler_enable <= 1'b1;
            r_state          <= StPropose;
          end
        end
        StPropose: begin
          r_sampler_enable <= 1'b0;
          r_cnt            <= '0;
          r_state          <= StWait;
        end
        StWait: begin
          if (r_cnt == WaitLast) r_state <= StCommit;
          else                   r_cnt   <= r_cnt + 8'd1;
        end
        // COMMIT also performs the index advance so a valid variable costs
        // 4+SAMPLER_LATENCY cycles; invalid segments advance via NEXT.
        StCommit, StNext: begin
          if (r_state == StCommit) begin
            if (w_in_range) begin
              r_var_write <= 1'b1;
              r_var_index <= r_idx[IDX_WIDTH-1:0];
              r_var_value <= w_clamped;
            end
            if (w_below || w_above) begin
              r_err <= sat_inc8(r_err);
`ifdef RANGE_CLAMP_EN
              r_var_write <= 1'b1;
              r_var_index <= r_idx[IDX_WIDTH-1:0];
              r_var_value <= w_clamped;
`endif
            end
          end
          if (w_last_var) begin
            r_idx   <= '0;
            r_sweep <= r_sweep + SWEEP_WIDTH'(1);
            if (w_last_sweep) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_state <= StFetch;
            end
          end else begin
            r_idx   <= r_idx + (IDX_WIDTH + 1)'(1);
            r_state <= StFetch;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_seg_addr       = r_idx[IDX_WIDTH-1:0];
  assign out_sampler_reset  = r_sampler_reset;
  assign out_sampler_enable = r_sampler_enable;
  assign out_sampler_seed   = r_seed;
  assign out_from           = r_from;
  assign out_to             = r_to;
  assign out_segment_type   = r_type;
  assign out_segment_weight = r_weight;
  assign out_var_write      = r_var_write;
  assign out_var_index      = r_var_index;
  assign out_var_value      = r_var_value;
  assign out_busy           = r_busy;
  assign out_done           = r_done;
  assign out_error_count    = r_err;

endmodule

// File: tb/tb_sampler_sweep_controller.sv
// Scoreboard bench for sampler_sweep_controller with a stub sampler and segment table.
module tb_sampler_sweep_controller;

  logic              clk = 1'b0;
  logic              in_reset = 1'b1;
  logic              in_start = 1'b0;
  logic [7:0]        in_seed = '0;
  logic [4:0]        in_num_vars = '0;
  logic [7:0]        in_num_sweeps = '0;
  logic [3:0]        out_seg_addr;
  logic signed [7:0] seg_from = '0;
  logic signed [7:0] seg_to = '0;
  logic [1:0]        seg_type = '0;
  logic signed [7:0] seg_weight = '0;
  logic              out_sampler_reset;
  logic              out_sampler_enable;
  logic [7:0]        out_sampler_seed;
  logic signed [7:0] out_from;
  logic signed [7:0] out_to;
  logic [1:0]        out_segment_type;
  logic signed [7:0] out_segment_weight;
  logic signed [7:0] proposal = '0;
  logic              out_var_write;
  logic [3:0]        out_var_index;
  logic signed [7:0] out_var_value;
  logic              out_busy;
  logic              out_done;
  logic [7:0]        out_error_count;

  always #5 clk = ~clk;

  sampler_sweep_controller dut (
    .in_clock          (clk),
    .in_reset          (in_reset),
    .in_start          (in_start),
    .in_seed           (in_seed),
    .in_num_vars       (in_num_vars),
    .in_num_sweeps     (in_num_sweeps),
    .out_seg_addr      (out_seg_addr),
    .in_seg_from       (seg_from),
    .in_seg_to         (seg_to),
    .in_seg_type       (seg_type),
    .in_seg_weight     (seg_weight),
    .out_sampler_reset (out_sampler_reset),
    .out_sampler_enable(out_sampler_enable),
    .out_sampler_seed  (out_sampler_seed),
    .out_from          (out_from),
    .out_to            (out_to),
    .out_segment_type  (out_segment_type),
    .out_segment_weight(out_segment_weight),
    .in_proposed_value (proposal),
    .out_var_write     (out_var_write),
    .out_var_index     (out_var_index),
    .out_var_value     (out_var_value),
    .out_busy          (out_busy),
    .out_done          (out_done),
    .out_error_count   (out_error_count)
  );

  // Segment table and stub sampler models.
  logic signed [7:0] tbl_from [16];
  logic signed [7:0] tbl_to   [16];
  logic [1:0]        tbl_type [16];
  logic signed [7:0] tbl_w    [16];
  logic signed [7:0] prop_tbl [16];

  always @(posedge clk) begin
    seg_from   <= tbl_from[out_seg_addr];
    seg_to     <= tbl_to[out_seg_addr];
    seg_type   <= tbl_type[out_seg_addr];
    seg_weight <= tbl_w[out_seg_addr];
    if (out_sampler_enable && !out_sampler_reset) proposal <= prop_tbl[out_seg_addr];
  end

  typedef struct {int idx; int val;} wr_t;
  wr_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int seed_cyc = 0;
  int last_seed = 0;
  int prop_cnt = 0;
  int last_wr_cyc = -1;
  bit gap_chk = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes and tallies strobes away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (out_var_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_index", int'(out_var_index), e.idx);
        check("write_value", int'(out_var_value), e.val);
        if (gap_chk && last_wr_cyc >= 0) check("write_spacing", cyc - last_wr_cyc, 5);
      end
      last_wr_cyc = cyc;
    end
    if (out_done) done_cnt++;
    if (out_sampler_reset) begin
      seed_cyc++;
      last_seed = int'(out_sampler_seed);
    end
    if (out_sampler_enable && !out_sampler_reset) prop_cnt++;
  end

  task automatic set_seg(input int i, input int f, input int t, input int ty, input int p);
    tbl_from[i] = 8'(f);
    tbl_to[i]   = 8'(t);
    tbl_type[i] = 2'(ty);
    tbl_w[i]    = 8'sd7;
    prop_tbl[i] = 8'(p);
  endtask

  task automatic push(input int i, input int v);
    wr_t e;
    e.idx = i;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int seed, input int nv, input int ns);
    @(posedge clk); #1;
    in_start = 1'b1;
    in_seed = 8'(seed);
    in_num_vars = 5'(nv);
    in_num_sweeps = 8'(ns);
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  task automatic begin_run(input int seed, input int nv, input int ns);
    @(posedge clk); #1;
    seed_cyc = 0;
    prop_cnt = 0;
    last_wr_cyc = -1;
    pulse_start(seed, nv, ns);
  endtask

  task automatic wait_done(input int snap);
    int n;
    n = 0;
    while (done_cnt == snap && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done_cnt != snap), 1);
    repeat (3) @(negedge clk);
    check("busy_after_done", int'(out_busy), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(out_busy), 0);
    check({tag, "_done"}, int'(out_done), 0);
    check({tag, "_enable"}, int'(out_sampler_enable), 0);
    check({tag, "_sreset"}, int'(out_sampler_reset), 0);
    check({tag, "_write"}, int'(out_var_write), 0);
    check({tag, "_err"}, int'(out_error_count), 0);
    check({tag, "_addr"}, int'(out_seg_addr), 0);
    check({tag, "_to"}, int'(out_to), 0);
    check({tag, "_seed"}, int'(out_sampler_seed), 0);
  endtask

  initial begin
    int snap;
    int n;
    for (int i = 0; i < 16; i++) set_seg(i, 0, 100, 1, 50);

    // Reset state
    repeat (3) @(posedge clk);
    #1 in_reset = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // 1: three valid variables, one sweep, boundary proposals 0 and 100
    set_seg(0, 0, 100, 1, 0);
    set_seg(1, 0, 100, 1, 55);
    set_seg(2, 0, 100, 1, 100);
    push(0, 0); push(1, 55); push(2, 100);
    gap_chk = 1'b1;
    snap = done_cnt;
    begin_run(4, 3, 1);
    wait_done(snap);
    gap_chk = 1'b0;
    check("t1_seed_cycles", seed_cyc, 2);
    check("t1_seed_value", last_seed, 4);
    check("t1_proposals", prop_cnt, 3);
    check("t1_err", int'(out_error_count), 0);
    check("t1_weight", int'(out_segment_weight), 7);
    check("t1_done_pulses", done_cnt - snap, 1);

    // 2: seed 0 is replaced by 1
    set_seg(0, -20, 20, 3, -20);
    push(0, -20);
    snap = done_cnt;
    begin_run(0, 1, 1);
    wait_done(snap);
    check("t2_seed_value", last_seed, 1);
    check("t2_err", int'(out_error_count), 0);

    // 3: invalid type and inverted bounds
    set_seg(0, 0, 100, 1, 20);
    set_seg(1, 0, 100, 0, 30);
    set_seg(2, 50, 10, 2, 30);
    push(0, 20);
    snap = done_cnt;
    begin_run(9, 3, 1);
    wait_done(snap);
    check("t3_err", int'(out_error_count), 2);
    check("t3_proposals", prop_cnt, 1);
    check("t3_done_pulses", done_cnt - snap, 1);

    // 4: out-of-range proposal above the segment
    set_seg(0, 0, 100, 1, 120);
`ifdef RANGE_CLAMP_EN
    push(0, 100);
`endif
    snap = done_cnt;
    begin_run(3, 1, 1);
    wait_done(snap);
    check("t4_err", int'(out_error_count), 1);

    // 5: two variables, three sweeps, stray start mid-run
    set_seg(0, 0, 100, 1, 5);
    set_seg(1, 0, 100, 2, 99);
    set_seg(2, 0, 100, 1, 77);
    for (int s = 0; s < 3; s++) begin
      push(0, 5);
      push(1, 99);
    end
    snap = done_cnt;
    begin_run(5, 2, 3);
    repeat (10) @(negedge clk);
    check("t5_busy_mid", int'(out_busy), 1);
    pulse_start(8, 3, 1);
    wait_done(snap);
    check("t5_done_pulses", done_cnt - snap, 1);
    check("t5_proposals", prop_cnt, 6);
    check("t5_err", int'(out_error_count), 0);

    // 6: reset during WAIT of the second variable
    set_seg(0, 0, 100, 1, 11);
    set_seg(1, 0, 100, 1, 22);
    set_seg(2, 0, 100, 1, 33);
    push(0, 11);
    snap = done_cnt;
    begin_run(6, 3, 1);
    n = 0;
    while (!(out_sampler_enable && !out_sampler_reset && out_seg_addr == 4'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_propose", int'(n < 200), 1);
    @(posedge clk); #1;
    in_reset = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;
    @(negedge clk);
    check_idle("t6_abort");
    repeat (10) @(negedge clk);
    check("t6_no_done", done_cnt - snap, 0);
    check("t6_queue", exp_q.size(), 0);
    exp_q.delete();

    // Fresh run after the abort
    push(0, 11); push(1, 22);
    snap = done_cnt;
    begin_run(6, 2, 1);
    wait_done(snap);
    check("t6_fresh_err", int'(out_error_count), 0);
    check("t6_fresh_done", done_cnt - snap, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sampler_sweep_controller.md
Name: sampler_sweep_controller

Overview:
- Sequences the Sampler through MCMC sweeps.
- Per sweep it steps a variable index 0..num_vars-1, reads that variable's chosen-segment descriptor (from, to, type, weight) from an external segment table, and drives the Sampler for one proposal.
- It then range-checks the proposal and issues a write to the variable register file.
- It sits between the top-level solver FSM (start/done) and the Sampler/segment table.

Parameters:
- DATA_WIDTH, 8, width of signed values (from, to, weight, proposal).
- IDX_WIDTH, 4, variable index width (max 16 variables).
- SWEEP_WIDTH, 8, sweep counter width.
- SAMPLER_LATENCY, 1, cycles from sampler enable edge to valid out_proposed_value.

Ports:
- in_clock  in  1  system clock
- in_reset  in  1  synchronous, active-high reset
- in_start  in  1  pulse; begins a run when idle
- in_seed  in  8  sampler seed, sampled on start
- in_num_vars  in  IDX_WIDTH+1  variables per sweep
- in_num_sweeps  in  SWEEP_WIDTH  sweeps per run
- out_seg_addr  out  IDX_WIDTH  segment table read address
- in_seg_from, in_seg_to  in  DATA_WIDTH signed  segment bounds, valid 1 cycle after address
- in_seg_type  in  2  segment type (0 invalid; 1, 2, 3 legal)
- in_seg_weight  in  DATA_WIDTH signed  segment weight
- out_sampler_reset  out  1  to Sampler in_reset
- out_sampler_enable  out  1  to Sampler in_enable
- out_sampler_seed  out  8  to Sampler in_seed
- out_from, out_to, out_segment_type, out_segment_weight  out  to Sampler
- in_proposed_value  in  DATA_WIDTH signed  from Sampler
- out_var_write  out  1  write strobe
- out_var_index  out  IDX_WIDTH  write index
- out_var_value  out  DATA_WIDTH signed  write data
- out_busy  out  1  run in progress
- out_done  out  1  one-cycle pulse at end of run
- out_error_count  out  8  count of rejected/invalid variables, saturating

Behaviour:
- Reset (synchronous, active-high): every output is 0, state IDLE, counters 0. Reset asserted mid-run aborts the run and gives the same result, with no done pulse.
- Reset mid-run also drops out_sampler_enable the same cycle it is registered.
- Registered outputs only.
- States:
  - IDLE: out_busy=0. If in_start=1, latch in_seed, in_num_vars and in_num_sweeps. If latched seed==0, substitute 1. Then go to SEED.
  - Start while busy: ignored.
  - in_num_vars==0 or in_num_sweeps==0: skip directly to DONE.
  - SEED: exactly 2 cycles with out_sampler_reset=1, out_sampler_enable=1, out_sampler_seed=latched seed. Then go to FETCH with idx=0, sweep=0.
  - FETCH: out_seg_addr=idx; 1 cycle; go to LOAD.
  - LOAD: register the descriptor onto out_from, out_to, out_segment_type and out_segment_weight. These are held stable until the next LOAD.
    - If type==0 or from>to (signed compare): error_count++ (saturate at 255), no sampler enable, go to NEXT.
    - Otherwise go to PROPOSE.
  - PROPOSE: out_sampler_enable=1 for exactly 1 cycle; then WAIT.
  - WAIT: SAMPLER_LATENCY cycles, enable=0.
  - COMMIT: sample in_proposed_value.
    - If it is within [from, to] inclusive: out_var_write=1 for 1 cycle, out_var_index=idx, out_var_value=proposal.
    - Otherwise: error_count++ and no write (default build).
  - NEXT:
    - If idx==num_vars-1: idx=0, sweep++. If sweep==num_sweeps-1, go to DONE; else go to FETCH.
    - Otherwise idx++ and go to FETCH.
  - DONE: out_done=1 for 1 cycle, out_busy=0 the following cycle; go to IDLE.
- Per-variable latency: 4+SAMPLER_LATENCY cycles (5 at default). An invalid segment takes 3 cycles (FETCH, LOAD, NEXT).
- out_busy is 1 from the cycle after start until DONE inclusive.
- Error count is cleared at each accepted start.
- All comparisons are signed DATA_WIDTH. The index counter is wide enough that num_vars=2^IDX_WIDTH terminates correctly.

Optional Feature:
- RANGE_CLAMP_EN defined: an out-of-range proposal in COMMIT is clamped to from (if below) or to (if above) and written. error_count still increments.
- Undefined: an out-of-range proposal is dropped with no write, as above.

Decomposition:
- Package sampler_ctrl_pkg holds:
  - state enum (IDLE, SEED, FETCH, LOAD, PROPOSE, WAIT, COMMIT, NEXT, DONE)
  - SEG_INVALID=0, SEG_TYPE1..3 constants
  - DATA_WIDTH and IDX_WIDTH defaults
  - SEED_CYCLES=2
- One sub-module, sampler_range_check: combinational in_range/below/above flags plus the clamped value. It is used in both LOAD (from>to check) and COMMIT.

Test Plan:
- Reset then start with seed=4, num_vars=3, num_sweeps=1, segments all [0,100] type 1 weight 7 -> out_sampler_reset high 2 cycles; 3 writes to idx 0,1,2 spaced 5 cycles apart; all values in 0..100; done pulse; error_count=0.
- Seed=0 -> out_sampler_seed=1 during SEED.
- Segment idx1 type=0 and idx2 from=50, to=10 -> no enable and no write for idx 1 or 2; error_count=2; done still asserted.
- Stub sampler returns 120 for range [0,100]:
  - default build: no write, error_count=1
  - RANGE_CLAMP_EN build: write value 100, error_count=1
- num_vars=2, num_sweeps=3 -> 6 writes, index order 0,1,0,1,0,1, single done. Start pulsed mid-run is ignored.
- Reset asserted during WAIT of the second variable -> next cycle all outputs 0, state IDLE, no done. A fresh start then runs normally.
